rx_capture: RTL and testbench
=============================

Name: rx_capture

Overview:
- Upstream acquisition stage for the wind-direction pipeline.
- Drives a 4-channel, 12-bit SPI ADC to capture one coherent set of transducer samples (channels 0..3).
- Presents the set as rx1..rx4 and pulses endata once per completed set.
- Output registers are double-buffered, so the downstream wind/speed logic never sees a mixed set.

Parameters:
- CLKDIV, 4: system clocks per SCLK half-period (legal range 2..255).
- CS_GAP, 2: system clocks csn stays high between channel frames (legal range 1..255).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request for one 4-channel capture; ignored while busy.
- continuous  in  1  when high, a new capture starts automatically on the cycle after endata.
- adc_sdo  in  1  ADC serial data out.
- adc_csn  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock; idles low.
- adc_sdi  out  1  ADC serial command in.
- rx1  out  12  channel 0 sample; unsigned, straight binary.
- rx2  out  12  channel 1 sample.
- rx3  out  12  channel 2 sample.
- rx4  out  12  channel 3 sample.
- endata  out  1  one-cycle strobe: rx1..rx4 updated this cycle.
- busy  out  1  high from the cycle after start is accepted until endata.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-frame):
  - Next cycle: csn=1, sclk=0, sdi=0, rx1..rx4=0, endata=0, busy=0, FSM=IDLE.
  - Partial captures are discarded and no endata is produced.
- Definitions:
  - SLOT = 33*CLKDIV + CS_GAP clocks per channel (default 134).
  - Frame = 16 SCLK periods, each period 2*CLKDIV clocks.
- FSM states: IDLE -> SETUP -> SHIFT -> GAP -> (next channel SETUP | UPDATE) -> IDLE.
  - IDLE:
    - start=1 is accepted at cycle t0; latch channel index 0.
    - At t0+1: csn=0, busy=1, enter SETUP.
  - SETUP: csn low, sclk low, for CLKDIV clocks; sdi carries command bit 15.
  - SHIFT: 16 SCLK periods; sclk low for CLKDIV clocks, then high for CLKDIV clocks.
  - Command word = {1,1,ch[1:0],12'b0}, MSB first.
    - sdi updates on each sclk falling edge (internally generated, so synchronous to the clock).
    - Bit 15 is presented during SETUP.
  - Data sampling:
    - adc_sdo is sampled on the system clock where sclk goes 0->1.
    - Rising edges 5..16 give data bits 11..0, MSB first.
    - Edges 1..4 are don't-care.
  - Frame end: after the 16th high phase, sclk=0, csn=1 and the FSM enters GAP.
  - GAP: csn high for CS_GAP clocks.
    - ch<3: increment ch, go to SETUP.
    - ch=3: go to UPDATE.
  - UPDATE (one cycle, at t0+4*SLOT+1):
    - rx1..rx4 load from shadow registers; endata=1; busy=0.
    - Next state is IDLE, or SETUP with ch=0 if continuous=1. In that case csn falls at t0+4*SLOT+2 and busy=1 again.
- Shadow registers are written per channel; rx outputs change only in UPDATE.
- start asserted while busy=1 or during UPDATE is ignored and not queued.
- start in the same cycle continuous is sampled high in UPDATE: a single capture begins (no double start).
- continuous deasserted mid-capture: the current set completes; no restart.
- Throughput at defaults: 4*134+1 = 537 clocks per set in continuous mode.

Decomposition:
- Package rx_capture_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, GAP, UPDATE);
  - CMD_PREFIX=2'b11, FRAME_BITS=16, DATA_BITS=12, FIRST_DATA_EDGE=5, NUM_CH=4.
- Sub-module spi_frame: one 16-bit SPI transfer.
  - Inputs: go, cmd[15:0].
  - Outputs: csn, sclk, sdi, data[11:0], done.
  - Parameterised by CLKDIV.
  - The top module owns sequencing of the 4 channels, GAP, the shadow/output registers and busy/endata.

Test Plan:
- ADC model returns 12'hA5C, 12'h3F1, 12'h800, 12'hFFF on ch0..3; start at t0 -> endata only at t0+537, with rx1..rx4 = A5C, 3F1, 800, FFF; exactly 4 csn low pulses, each 32*CLKDIV+CLKDIV clocks long.
- Check sdi bitstream per frame -> 1,1,ch[1],ch[0] followed by 12 zeros, for ch = 0,1,2,3 in order; sclk shows 16 rising edges per frame and idles low.
- Second capture with ADC values changed to 001, 002, 003, 004 -> rx outputs hold the old values until the UPDATE cycle, then all four change in the same cycle.
- start pulsed again at t0+100 and at the UPDATE cycle, with continuous=0 -> both ignored; a single endata; busy=0 afterwards.
- continuous=1 -> endata pulses spaced exactly 537 clocks apart; continuous dropped mid-set -> that set completes and no further csn activity follows.
- Reset asserted during the SHIFT of ch2 -> next cycle csn=1, sclk=0, rx*=0, busy=0; no endata afterwards; a fresh start then completes normally.

Source files
------------

// File: rtl/rx_capture_pkg.sv
// Shared types and constants for the rx_capture SPI ADC acquisition block.
package rx_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        UPDATE
    } state_t;

    localparam logic [1:0]  CMD_PREFIX      = 2'b11;
    localparam int unsigned FRAME_BITS      = 16;
    localparam int unsigned DATA_BITS       = 12;
    localparam int unsigned FIRST_DATA_EDGE = 5;
    localparam int unsigned NUM_CH          = 4;
    localparam int unsigned CH_W            = 2;

    // ADC conversion command for one channel, sent MSB first
    function automatic logic [FRAME_BITS-1:0] make_cmd(input logic [CH_W-1:0] ch);
        return {CMD_PREFIX, ch, {(FRAME_BITS-4){1'b0}}};
    endfunction

endpackage

// File: rtl/rx_capture_spi_frame.sv
// One 16-bit SPI transfer: CLKDIV-clock setup, 16 SCLK periods, 12-bit result.
module spi_frame
    import rx_capture_pkg::*;
#(
    parameter int unsigned CLKDIV = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic [FRAME_BITS-1:0] cmd,
    input  logic                  sdo,
    output logic                  csn,
    output logic                  sclk,
    output logic                  sdi,
    output logic [DATA_BITS-1:0]  data,
    output logic                  done
);

    localparam int unsigned CW        = 8;
    localparam int unsigned HW        = 6;
    localparam int unsigned LAST_HALF = 2 * FRAME_BITS;
    localparam int unsigned DATA_HALF = 2 * FIRST_DATA_EDGE - 1;

    logic                  active;
    logic [CW-1:0]         cnt;
    logic [HW-1:0]         half;
    logic [FRAME_BITS-1:0] sh;
    logic                  half_end_c;

    assign half_end_c = (cnt == CW'(CLKDIV - 1));

    // Half 0 is setup; odd halves are SCLK low, even halves SCLK high.
    always_ff @(posedge clock) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            half   <= '0;
            sh     <= '0;
            csn    <= 1'b1;
            sclk   <= 1'b0;
            sdi    <= 1'b0;
            data   <= '0;
            done   <= 1'b0;
        end else begin
            // done marks the last csn-low cycle so the caller's gap count lines up
            done <= active && (half == HW'(LAST_HALF)) && (cnt == CW'(CLKDIV - 2));
            if (go && !active) begin
                active <= 1'b1;
                cnt    <= '0;
                half   <= '0;
                csn    <= 1'b0;
                sclk   <= 1'b0;
                sdi    <= cmd[FRAME_BITS-1];
                sh     <= {cmd[FRAME_BITS-2:0], 1'b0};
            end else if (active) begin
                if (!half_end_c) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                    if (half == HW'(LAST_HALF)) begin
                        active <= 1'b0;
                        csn    <= 1'b1;
                        sclk   <= 1'b0;
                        sdi    <= 1'b0;
                    end else begin
                        half <= half + 1'b1;
                        if (half[0]) begin
                            sclk <= 1'b1;
                            if (half >= HW'(DATA_HALF)) begin
                                data <= {data[DATA_BITS-2:0], sdo};
                            end
                        end else if (half != '0) begin
                            sclk <= 1'b0;
                            sdi  <= sh[FRAME_BITS-1];
                            sh   <= {sh[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rx_capture.sv
// Captures one coherent 4-channel ADC sample set and presents it double-buffered.
module rx_capture
    import rx_capture_pkg::*;
#(
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned CS_GAP = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 adc_sdo,
    output logic                 adc_csn,
    output logic                 adc_sclk,
    output logic                 adc_sdi,
    output logic [DATA_BITS-1:0] rx1,
    output logic [DATA_BITS-1:0] rx2,
    output logic [DATA_BITS-1:0] rx3,
    output logic [DATA_BITS-1:0] rx4,
    output logic                 endata,
    output logic                 busy
);

    localparam int unsigned CW = 8;

    state_t               state, state_d;
    logic [CH_W-1:0]      ch, ch_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic                 busy_d;
    logic                 endata_d;
    logic                 go_c;
    logic                 capture_c;
    logic                 update_c;
    logic                 frame_done;
    logic [DATA_BITS-1:0] frame_data;
    logic [DATA_BITS-1:0] shadow [NUM_CH];

    spi_frame #(
        .CLKDIV (CLKDIV)
    ) u_frame (
        .clock (clock),
        .reset (reset),
        .go    (go_c),
        .cmd   (make_cmd(ch_d)),
        .sdo   (adc_sdo),
        .csn   (adc_csn),
        .sclk  (adc_sclk),
        .sdi   (adc_sdi),
        .data  (frame_data),
        .done  (frame_done)
    );

    // Channel sequencing, gap timing and set hand-off
    always_comb begin
        state_d   = state;
        ch_d      = ch;
        cnt_d     = cnt;
        busy_d    = busy;
        endata_d  = 1'b0;
        go_c      = 1'b0;
        capture_c = 1'b0;
        update_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    go_c    = 1'b1;
                    ch_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt == CW'(CLKDIV - 1)) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (frame_done) begin
                    capture_c = 1'b1;
                    cnt_d     = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (cnt == CW'(CS_GAP - 1)) begin
                    cnt_d = '0;
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        update_c = 1'b1;
                        endata_d = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = UPDATE;
                    end else begin
                        ch_d    = ch + 1'b1;
                        go_c    = 1'b1;
                        state_d = SETUP;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            UPDATE: begin
                // start is deliberately not looked at here: at most one capture begins
                if (continuous) begin
                    go_c    = 1'b1;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            ch     <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            endata <= 1'b0;
            rx1    <= '0;
            rx2    <= '0;
            rx3    <= '0;
            rx4    <= '0;
        end else begin
            state  <= state_d;
            ch     <= ch_d;
            cnt    <= cnt_d;
            busy   <= busy_d;
            endata <= endata_d;
            if (update_c) begin
                rx1 <= shadow[0];
                rx2 <= shadow[1];
                rx3 <= shadow[2];
                rx4 <= shadow[3];
            end
        end
    end

    // Shadow set; stale contents never reach rx because a set always rewrites all four
    always_ff @(posedge clock) begin
        if (capture_c) begin
            shadow[ch] <= frame_data;
        end
    end

endmodule

// File: tb/tb_rx_capture.sv
// Directed bench for rx_capture with a behavioural 4-channel 12-bit SPI ADC.
module tb_rx_capture;

    localparam int CLKDIV  = 4;
    localparam int CS_GAP  = 2;
    localparam int SLOT    = 33 * CLKDIV + CS_GAP;  // 134
    localparam int SET_LAT = 4 * SLOT + 1;          // 537
    localparam int PULSE   = 33 * CLKDIV;           // 132

    typedef struct packed {
        logic [3:0][11:0] adc;
        logic [3:0][11:0] exp_rx;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        adc_sdo = 1'b0;
    logic        adc_csn, adc_sclk, adc_sdi;
    logic [11:0] rx1, rx2, rx3, rx4;
    logic        endata, busy;
    wire [3:0][11:0] rx_all = {rx4, rx3, rx2, rx1};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    rx_capture #(
        .CLKDIV (CLKDIV),
        .CS_GAP (CS_GAP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .adc_sdo    (adc_sdo),
        .adc_csn    (adc_csn),
        .adc_sclk   (adc_sclk),
        .adc_sdi    (adc_sdi),
        .rx1        (rx1),
        .rx2        (rx2),
        .rx3        (rx3),
        .rx4        (rx4),
        .endata     (endata),
        .busy       (busy)
    );

    initial forever #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ADC model: decodes the channel from the command, shifts data out on SCLK falls
    logic [3:0][11:0] adc_vals = '0;
    logic [15:0]      cmd_seen = '0;
    logic [1:0]       ch_seen = '0;
    logic [11:0]      word;
    int               rise_n = 0;
    logic [15:0]      frame_q [$];
    int               rises_q [$];
    int               pulse_q [$];
    int               low_len = 0;

    always @(negedge adc_csn) begin
        rise_n   = 0;
        cmd_seen = '0;
    end

    always @(posedge adc_sclk) begin
        if (adc_csn === 1'b0) begin
            cmd_seen = {cmd_seen[14:0], adc_sdi};
            rise_n++;
            if (rise_n == 4) ch_seen = cmd_seen[1:0];
        end
    end

    always @(negedge adc_sclk) begin
        if (adc_csn === 1'b0 && rise_n >= 4 && rise_n < 16) begin
            word    = adc_vals[ch_seen];
            adc_sdo = word[15 - rise_n];
        end
    end

    always @(posedge adc_csn) begin
        frame_q.push_back(cmd_seen);
        rises_q.push_back(rise_n);
    end

    always @(negedge clock) begin
        if (adc_csn === 1'b0) low_len++;
        else if (low_len != 0) begin
            pulse_q.push_back(low_len);
            low_len = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        #1;
        frame_q.delete();
        rises_q.delete();
        pulse_q.delete();
        low_len = 0;
    endtask

    // One start-triggered set, then latency, data, hold, framing and command checks.
    task automatic run_capture(input vec_t v, input string tag);
        logic [3:0][11:0] prev;
        logic [3:0][15:0] exp_cmd;
        int t0;
        bit early;
        exp_cmd  = {16'hF000, 16'hE000, 16'hD000, 16'hC000};
        adc_vals = v.adc;
        clear_mon();
        prev  = rx_all;
        t0    = cyc;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, " csn_low_t0+1"}, 32'(adc_csn), 32'd0);
        check({tag, " busy_t0+1"}, 32'(busy), 32'd1);
        early = 1'b0;
        while (!endata && cyc < t0 + 2 * SET_LAT) begin
            if (rx_all !== prev) early = 1'b1;
            @(negedge clock);
        end
        check({tag, " endata_seen"}, 32'(endata), 32'd1);
        check({tag, " endata_latency"}, 32'(cyc - t0), 32'(SET_LAT));
        check({tag, " rx_held_until_update"}, 32'(early), 32'd0);
        for (int c = 0; c < 4; c++)
            check($sformatf("%s rx%0d", tag, c + 1), 32'(rx_all[c]), 32'(v.exp_rx[c]));
        @(negedge clock);
        check({tag, " endata_one_cycle"}, 32'(endata), 32'd0);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        repeat (5) @(negedge clock);
        check({tag, " sclk_idle"}, 32'(adc_sclk), 32'd0);
        check({tag, " csn_pulses"}, 32'(pulse_q.size()), 32'd4);
        for (int j = 0; j < pulse_q.size(); j++)
            check($sformatf("%s csn_len[%0d]", tag, j), 32'(pulse_q[j]), 32'(PULSE));
        check({tag, " frames"}, 32'(frame_q.size()), 32'd4);
        for (int j = 0; j < frame_q.size() && j < 4; j++) begin
            check($sformatf("%s sdi_cmd[%0d]", tag, j), 32'(frame_q[j]), 32'(exp_cmd[j]));
            check($sformatf("%s sclk_rises[%0d]", tag, j), 32'(rises_q[j]), 32'd16);
        end
    endtask

    vec_t vecs [3];
    int   t0;
    int   n_end;
    int   end_at [8];

    initial begin
        vecs[0] = '{adc: {12'hFFF, 12'h800, 12'h3F1, 12'hA5C}, exp_rx: {12'hFFF, 12'h800, 12'h3F1, 12'hA5C}};
        vecs[1] = '{adc: {12'h004, 12'h003, 12'h002, 12'h001}, exp_rx: {12'h004, 12'h003, 12'h002, 12'h001}};
        vecs[2] = '{adc: {12'hFFF, 12'h000, 12'hFFF, 12'h000}, exp_rx: {12'hFFF, 12'h000, 12'hFFF, 12'h000}};

        repeat (3) @(negedge clock);
        check("reset csn", 32'(adc_csn), 32'd1);
        check("reset sclk", 32'(adc_sclk), 32'd0);
        check("reset sdi", 32'(adc_sdi), 32'd0);
        check("reset rx", 32'(rx_all[0] | rx_all[1] | rx_all[2] | rx_all[3]), 32'd0);
        check("reset endata", 32'(endata), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 3; i++) run_capture(vecs[i], $sformatf("vec%0d", i));

        // start repeated while busy and in the UPDATE cycle is ignored
        adc_vals = {12'hABC, 12'h789, 12'h456, 12'h123};
        clear_mon();
        n_end = 0;
        end_at[0] = 0;
        t0 = cyc;
        start = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clock);
            start = (cyc == t0 + 100) || (cyc == t0 + SET_LAT);
            if (endata) begin
                n_end++;
                end_at[0] = cyc;
            end
        end
        check("ignore endata_count", 32'(n_end), 32'd1);
        check("ignore endata_time", 32'(end_at[0] - t0), 32'(SET_LAT));
        check("ignore busy_after", 32'(busy), 32'd0);
        check("ignore csn_pulses", 32'(pulse_q.size()), 32'd4);
        check("ignore rx1", 32'(rx1), 32'h123);
        check("ignore rx4", 32'(rx4), 32'hABC);

        // continuous mode, extra start in an UPDATE cycle, then continuous dropped mid-set
        adc_vals = {12'h0F0, 12'h00F, 12'hF00, 12'h5A5};
        clear_mon();
        continuous = 1'b1;
        n_end = 0;
        t0 = cyc;
        start = 1'b1;
        for (int k = 0; k < 3300; k++) begin
            @(negedge clock);
            start = (cyc == t0 + 2 * SET_LAT);
            if (cyc == t0 + 3 * SET_LAT + 200) continuous = 1'b0;
            if (endata) begin
                if (n_end < 8) end_at[n_end] = cyc;
                n_end++;
            end
        end
        check("cont endata_count", 32'(n_end), 32'd4);
        for (int m = 0; m < 4 && m < n_end; m++)
            check($sformatf("cont endata_time[%0d]", m), 32'(end_at[m] - t0), 32'((m + 1) * SET_LAT));
        check("cont csn_pulses", 32'(pulse_q.size()), 32'd16);
        check("cont busy_after", 32'(busy), 32'd0);
        check("cont rx3", 32'(rx3), 32'h00F);

        // reset during SHIFT of channel 2 discards the set
        adc_vals = {12'h111, 12'h222, 12'h333, 12'h444};
        t0 = cyc;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (cyc < t0 + 2 * SLOT + 1 + CLKDIV + 10) @(negedge clock);
        check("midreset csn_active", 32'(adc_csn), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset csn", 32'(adc_csn), 32'd1);
        check("midreset sclk", 32'(adc_sclk), 32'd0);
        check("midreset rx", 32'(rx_all[0] | rx_all[1] | rx_all[2] | rx_all[3]), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset endata", 32'(endata), 32'd0);
        clear_mon();
        n_end = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            if (endata) n_end++;
        end
        check("midreset no_endata", 32'(n_end), 32'd0);
        check("midreset no_csn", 32'(pulse_q.size()), 32'd0);
        run_capture(vecs[0], "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
